tt_um_b_10_seq_divider: RTL and testbench

TT_UM_B_10_SEQ_DIVIDER -- requirements
Module: tt_um_b_10_seq_divider

---
 rtl/tt_um_b_10_seq_divider.sv | 138 +++++++++++++
 tb/tb_tt_um_b_10_seq_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_b_10_seq_divider.sv
// Sequential 8-by-4 restoring divider: P = M*Q + R, one quotient bit per clock.
// Quotient overflow (P/M >= 16) and divide-by-zero both report err with Q=R=4'hF.
module tt_um_b_10_seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned DW = 8;  // dividend / internal quotient width
  localparam int unsigned MW = 4;  // divisor, result-nibble width
  localparam int unsigned CW = 4;  // iteration counter width

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          start_q, start_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [MW-1:0] rem_q, rem_d;
  logic [MW-1:0] m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] res_q, res_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          start_acc;
  logic [MW:0]   shift_rem;
  logic [MW+1:0] diff;
  logic          q_bit;
  logic [MW-1:0] new_rem;
  logic [DW-1:0] quot_nx;
  logic          unused_c;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    start_acc = uio_in[4] & ~start_q;
    shift_rem = {rem_q, dvd_q[DW-1]};
    diff      = {1'b0, shift_rem} - {2'b00, m_q};
    q_bit     = ~diff[MW+1];
    new_rem   = q_bit ? diff[MW-1:0] : shift_rem[MW-1:0];
    quot_nx   = {dvd_q[DW-2:0], q_bit};
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    start_d = uio_in[4];
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          if (uio_in[MW-1:0] == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            res_d   = '1;
          end else begin
            state_d = S_RUN;
            dvd_d   = ui_in;
            m_d     = uio_in[MW-1:0];
            rem_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        dvd_d = quot_nx;
        rem_d = new_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (quot_nx[DW-1:MW] != '0) begin
            err_d = 1'b1;
            res_d = '1;
          end else begin
            err_d = 1'b0;
            res_d = {new_rem, quot_nx[MW-1:0]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      dvd_q   <= '0;
      rem_q   <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign uo_out   = res_q;
  assign uio_out  = {err_q, done_q, busy_q, 5'b0_0000};
  assign uio_oe   = 8'b1110_0000;
  assign unused_c = ^{ena, uio_in[7:5], diff[MW]};

endmodule

// File: tb/tb_tt_um_b_10_seq_divider.sv
// Self-checking bench for the sequential divider: directed scenarios, an
// exhaustive non-overflow sweep and random operations against an arithmetic model.
module tb_tt_um_b_10_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_uo;

  tt_um_b_10_seq_divider dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // {err, uo_out} expected at completion, straight from the division rule.
  function automatic logic [8:0] model(input int p, input int m);
    int q;
    int r;
    if (m == 0) return 9'h1FF;
    q = p / m;
    r = p % m;
    if (q > 15) return 9'h1FF;
    return {1'b0, 4'(r), 4'(q)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive operands with a rising start and clock the launch edge N.
  task automatic launch(input logic [7:0] p, input logic [3:0] m);
    ui_in  = p;
    uio_in = {3'($urandom_range(0, 7)), 1'b1, m};
    tick();
  endtask

  // Called just after edge N; checks RUN/DONE behaviour through completion.
  task automatic finish_op(input int p, input int m, input bit hold_start, input bit perturb);
    logic [8:0] exp_v;
    exp_v = model(p, m);
    if (m == 0) begin
      chk("z_done", 16'(uio_out[6]), 16'd1);
      chk("z_busy", 16'(uio_out[5]), 16'd0);
      chk("z_err", 16'(uio_out[7]), 16'd1);
      chk("z_uo", 16'(uo_out), 16'hFF);
      if (!hold_start) uio_in[4] = 1'b0;
      tick();
      chk("z_busy2", 16'(uio_out[5]), 16'd0);
      chk("z_done2", 16'(uio_out[6]), 16'd1);
    end else begin
      chk("launch_busy", 16'(uio_out[5]), 16'd1);
      chk("launch_done", 16'(uio_out[6]), 16'd0);
      chk("launch_err", 16'(uio_out[7]), 16'd0);
      chk("launch_uo", 16'(uo_out), 16'(prev_uo));
      for (int i = 1; i <= 8; i++) begin
        if (i == 1 && !hold_start) uio_in[4] = 1'b0;
        if (perturb && i == 3) begin
          ui_in  = 8'($urandom);
          uio_in = {3'b000, 1'b1, 4'($urandom_range(0, 15))};
        end
        if (perturb && i == 4) uio_in[4] = 1'b0;
        tick();
        if (i < 8) begin
          chk("run_busy", 16'(uio_out[5]), 16'd1);
          chk("run_uo", 16'(uo_out), 16'(prev_uo));
          chk("run_err", 16'(uio_out[7]), 16'd0);
        end
      end
      chk("cmp_busy", 16'(uio_out[5]), 16'd0);
      chk("cmp_done", 16'(uio_out[6]), 16'd1);
      chk("cmp_err", 16'(uio_out[7]), 16'(exp_v[8]));
      chk("cmp_uo", 16'(uo_out), 16'(exp_v[7:0]));
    end
    prev_uo = exp_v[7:0];
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    prev_uo = 8'h00;
    #3;
    chk("rst_uo", 16'(uo_out), 16'h00);
    chk("rst_uio_out", 16'(uio_out), 16'h00);
    chk("rst_oe", 16'(uio_oe), 16'hE0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_uio_out", 16'(uio_out), 16'h00);

    // Directed operations with known answers.
    launch(8'd143, 4'd11); finish_op(143, 11, 1'b0, 1'b0);
    chk("d143_11", 16'(uo_out), 16'h0D);
    launch(8'd200, 4'd13); finish_op(200, 13, 1'b0, 1'b0);
    chk("d200_13", 16'(uo_out), 16'h5F);
    launch(8'd255, 4'd1);  finish_op(255, 1, 1'b0, 1'b0);
    chk("d255_1", 16'(uio_out[7:5]), 16'b110);
    launch(8'd77, 4'd0);   finish_op(77, 0, 1'b0, 1'b0);
    launch(8'd90, 4'd7);   finish_op(90, 7, 1'b0, 1'b1);
    chk("d90_7", 16'(uo_out), 16'h6C);
    chk("oe_const", 16'(uio_oe), 16'hE0);

    // Result persists while idle in DONE.
    for (int i = 0; i < 5; i++) tick();
    chk("hold_uo", 16'(uo_out), 16'h6C);
    chk("hold_done", 16'(uio_out[6]), 16'd1);

    // Reset asserted mid-run clears everything immediately.
    launch(8'd170, 4'd9);
    uio_in[4] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_uo", 16'(uo_out), 16'h00);
    chk("abort_uio_out", 16'(uio_out), 16'h00);
    prev_uo = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 16'(uio_out), 16'h00);
    launch(8'd225, 4'd15); finish_op(225, 15, 1'b0, 1'b0);
    chk("d225_15", 16'(uo_out), 16'h0F);

    // Start already high when reset releases launches on the first edge.
    rst_n  = 1'b0;
    ui_in  = 8'd100;
    uio_in = {3'b000, 1'b1, 4'd7};
    prev_uo = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    finish_op(100, 7, 1'b0, 1'b0);
    chk("d100_7", 16'(uo_out), 16'h2E);
    tick();

    // Exhaustive non-overflow sweep; start stays high past completion.
    for (int m = 1; m <= 15; m++) begin
      for (int p = 0; p < 16 * m; p++) begin
        launch(8'(p), 4'(m));
        finish_op(p, m, 1'b1, 1'b0);
        tick();
        tick();
        chk("sw_hold_busy", 16'(uio_out[5]), 16'd0);
        chk("sw_hold_uo", 16'(uo_out), 16'(prev_uo));
        uio_in[4] = 1'b0;
        tick();
      end
    end

    // Random operations, including overflow, zero divisor and RUN perturbation.
    for (int k = 0; k < 80; k++) begin
      int p;
      int m;
      bit pert;
      p    = int'($urandom_range(0, 255));
      m    = int'($urandom_range(0, 15));
      pert = 1'($urandom_range(0, 1));
      launch(8'(p), 4'(m));
      finish_op(p, m, 1'b0, pert);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
